// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states and an
// alignment helper used when MEM_ALIGN_CHECK_EN is defined.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD_WAIT = 2'b01,
    ST_RMW_MERGE = 2'b10
  } state_t;

  // Size 2'b11 is handled as a word, so any size with bit 1 set is a word.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SZ_HALF) return addr_lo[0];
    if (is_word(size)) return |addr_lo;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational; a word access passes read or write data straight through.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_base;

  always_comb begin
    byte_base  = {addr_lo, 3'b000};
    byte_sel   = rdata[byte_base +: 8];
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data  = rdata;
    merge_data = wdata;
    if (size == SZ_BYTE) begin
      load_data  = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      merge_data = rdata;
      merge_data[byte_base +: 8] = wdata[7:0];
    end else if (size == SZ_HALF) begin
      load_data  = {{16{sign_ext & half_sel[15]}}, half_sel};
      merge_data = rdata;
      if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
      else            merge_data[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: word stores go straight through, loads and sub-word
// stores take one extra cycle. Optional alignment trap via MEM_ALIGN_CHECK_EN.
//
// state        | meaning
// ST_IDLE      | accept request; word store writes immediately
// ST_LOAD_WAIT | read word returned; present extended load_data for one cycle
// ST_RMW_MERGE | read word returned; merge latched lane(s) and write back
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              addr_err,
`endif
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [31:0]       wdata_q;
  logic [31:0]       load_q;
  logic [31:0]       lane_load;
  logic [31:0]       lane_merge;
  logic              bad_align;
  logic              err;

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_align = misaligned(mem_size, mem_addr[1:0]);
  assign addr_err  = err;
`else
  assign bad_align = 1'b0;
`endif

  mem_lane_unit u_lane (
    .size       (size_q),
    .sign_ext   (signed_q),
    .addr_lo    (addr_q[1:0]),
    .rdata      (dmem_rdata),
    .wdata      (wdata_q),
    .load_data  (lane_load),
    .merge_data (lane_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      load_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && mem_en) begin
        addr_q   <= mem_addr;
        size_q   <= mem_size;
        signed_q <= mem_signed;
        wdata_q  <= mem_wdata;
      end
      if (state == ST_LOAD_WAIT) load_q <= lane_load;
    end
  end

  // Outputs are forced quiet while rst is high so an aborted access never writes.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    load_valid = 1'b0;
    dmem_we    = 1'b0;
    err        = 1'b0;
    load_data  = load_q;
    dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    dmem_wdata = lane_merge;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          dmem_addr  = {mem_addr[ADDR_W-1:2], 2'b00};
          dmem_wdata = mem_wdata;
          if (mem_en) begin
            if (bad_align) begin
              err = 1'b1;
            end else if (!mem_we) begin
              stall     = 1'b1;
              state_nxt = ST_LOAD_WAIT;
            end else if (is_word(mem_size)) begin
              dmem_we = 1'b1;
            end else begin
              stall     = 1'b1;
              state_nxt = ST_RMW_MERGE;
            end
          end
        end
        ST_LOAD_WAIT: begin
          load_valid = 1'b1;
          load_data  = lane_load;
          state_nxt  = ST_IDLE;
        end
        ST_RMW_MERGE: begin
          dmem_we   = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: request-level reference memory model
// drives per-cycle expectations; a negedge process compares every cycle.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_we, mem_signed;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall, load_valid, dmem_we;
  logic [31:0] load_data, dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_size   (mem_size),
    .mem_signed (mem_signed),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stall      (stall),
    .load_valid (load_valid),
    .load_data  (load_data),
`ifdef MEM_ALIGN_CHECK_EN
    .addr_err   (addr_err),
`endif
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory with registered read.
  logic [31:0] dmem [64];
  always @(posedge clk) begin
    if (dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
    dmem_rdata <= dmem[dmem_addr[7:2]];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents and load result derived from the byte rules.
  logic [31:0] ref_mem [64];

  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int lane;
    lane = int'(a[1:0]);
    if (sz == 2'b00) begin
      v = (w >> (8 * lane)) & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * (lane / 2))) & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] mask;
    int sh, lane;
    lane = int'(a[1:0]);
    if (sz == 2'b00) begin
      mask = 32'h0000_00FF; sh = 8 * lane;
    end else if (sz == 2'b01) begin
      mask = 32'h0000_FFFF; sh = 16 * (lane / 2);
    end else begin
      return wd;
    end
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b01) return a[0];
    if (sz[1]) return a[1] | a[0];
    return 1'b0;
  endfunction

  // Per-cycle expectations, written by the stimulus and read by the compare process.
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_valid = 1'b0, exp_we = 1'b0, exp_err = 1'b0;
  logic        chk_addr = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_ld = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk_bit("stall", stall, exp_stall);
      chk_bit("load_valid", load_valid, exp_valid);
      chk_bit("dmem_we", dmem_we, exp_we);
      chk_word("load_data", load_data, exp_ld);
      if (chk_addr && (exp_stall || exp_we)) chk_word("dmem_addr", dmem_addr, exp_addr);
      if (exp_we) chk_word("dmem_wdata", dmem_wdata, exp_wdata);
`ifdef MEM_ALIGN_CHECK_EN
      chk_bit("addr_err", addr_err, exp_err);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_en = 1'b0;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_we = 1'b0; exp_err = 1'b0; chk_addr = 1'b0;
    step();
  endtask

  task automatic req(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] mval);
    int idx;
    idx = int'(a[7:2]);
    mem_en = 1'b1; mem_we = we; mem_size = sz; mem_signed = sg; mem_addr = a; mem_wdata = wd;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
    exp_addr = {a[31:2], 2'b00}; chk_addr = 1'b1;
    mval = '0;
`ifdef MEM_ALIGN_CHECK_EN
    if (misal(sz, a)) begin
      exp_err = 1'b1;
      step();
      return;
    end
`endif
    if (!we) begin
      exp_stall = 1'b1;
      step();
      exp_stall = 1'b0; exp_valid = 1'b1;
      mval = ext_load(ref_mem[idx], sz, sg, a);
      exp_ld = mval;
      step();
    end else if (sz[1]) begin
      exp_we = 1'b1; exp_wdata = wd;
      step();
      ref_mem[idx] = wd;
      mval = wd;
    end else begin
      exp_stall = 1'b1;
      step();
      exp_stall = 1'b0; exp_we = 1'b1;
      mval = merge(ref_mem[idx], wd, sz, a);
      exp_wdata = mval;
      step();
      ref_mem[idx] = mval;
    end
    exp_valid = 1'b0; exp_we = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    rst = 1'b1;
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_signed = 1'b0;
    mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk_en = 1'b1;                         // reset held with a pending request
    step();
    rst = 1'b0;
    idle();

    req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, r);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    chk_word("pin_lw_0x10", r, 32'h1122_3344);
    req(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56AA, r);
    idle();
    chk_word("pin_dmem_sb", dmem[4], 32'h1122_AA44);
    req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, r);
    chk_word("pin_lb_signed", r, 32'hFFFF_FFAA);
    req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, r);
    chk_word("pin_lbu", r, 32'h0000_00AA);
    req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, r);
    chk_word("pin_lh_signed", r, 32'h0000_1122);
    idle();
    idle();

    // load immediately followed by a word store
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    req(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFE_BABE, r);
    req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, r);
    chk_word("pin_lhu_hi", r, 32'h0000_CAFE);
    req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, r);
    req(1'b1, 2'b01, 1'b0, 32'h14, 32'hFFFF_8001, r);
    req(1'b1, 2'b00, 1'b0, 32'h17, 32'h0000_005A, r);
    idle();
    chk_word("pin_dmem_14", dmem[5], 32'h5AFE_8001);
    req(1'b0, 2'b11, 1'b1, 32'h14, 32'h0, r);
    req(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, r);
    req(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, r);
    chk_word("pin_lb_0x15", r, 32'hFFFF_FF80);

`ifndef MEM_ALIGN_CHECK_EN
    req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, r);
    req(1'b1, 2'b01, 1'b0, 32'h15, 32'h0000_7777, r);
    req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, r);
    chk_word("pin_sh_lowbit_ignored", r, 32'h5AFE_7777);
`endif

    // reset while the merge is pending must drop the write
    req(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_BEEF, r);
    idle();
    mem_en = 1'b1; mem_we = 1'b1; mem_size = 2'b01; mem_addr = 32'h10; mem_wdata = 32'h0000_BEEF;
    exp_stall = 1'b1; exp_addr = 32'h10; chk_addr = 1'b1;
    step();
    rst = 1'b1;
    exp_stall = 1'b0; exp_ld = '0;
    step();
    rst = 1'b0;
    idle();
    chk_word("reset_abort_mem", dmem[4], ref_mem[4]);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);

`ifdef MEM_ALIGN_CHECK_EN
    req(1'b1, 2'b10, 1'b0, 32'h13, 32'hFFFF_FFFF, r);
    req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, r);
    idle();
    chk_word("align_mem_unchanged", dmem[4], ref_mem[4]);
`endif

    idle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
